reset_seq: RTL

Parametrised reset sequencer, successor to the single-output power-on reset generator. It sits directly downstream of the clock/reset generator and fans one core reset out into NUM_RST staggered, per-domain active-low resets. Beyond power-on, it also re-runs the sequence on three triggers: a software request, a debounced external reset button, and an optional watchdog timeout. The cause of the last reset is reported.

---
 rtl/reset_seq_pkg.sv | 30 +++
 rtl/rst_debounce.sv | 63 ++++++
 rtl/reset_seq.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/reset_seq_pkg.sv
// ============================================================================
// Module      : reset_seq_pkg
// Description : Shared state encodings, reset-cause codes and the counter
//               width check used by the reset sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reset_seq_pkg;

    localparam logic [1:0] ST_ASSERT  = 2'd0;
    localparam logic [1:0] ST_RELEASE = 2'd1;
    localparam logic [1:0] ST_RUN     = 2'd2;

    localparam logic [1:0] CAUSE_POR = 2'b00;
    localparam logic [1:0] CAUSE_SW  = 2'b01;
    localparam logic [1:0] CAUSE_EXT = 2'b10;
    localparam logic [1:0] CAUSE_WDT = 2'b11;

    // True when a cycle count can be held in a counter of the given width.
    function automatic bit cycles_fit(input int unsigned width, input longint unsigned cycles);
        if (width >= 63) begin
            return 1'b1;
        end
        return cycles < (64'd1 << width);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rst_debounce.sv
// ============================================================================
// Module      : rst_debounce
// Description : Two-flop synchroniser plus stable-low debouncer for an
//               active-low reset button; emits one pulse per press.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rst_debounce #(
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int CTR_WIDTH       = 24
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n_i,
    output logic press_o
);

    localparam logic [CTR_WIDTH-1:0] c_deb_cycles = CTR_WIDTH'(DEBOUNCE_CYCLES);

    logic                 sync1_q;
    logic                 sync2_q;
    logic                 armed_q;
    logic                 armed_d;
    logic [CTR_WIDTH-1:0] cnt_q;
    logic [CTR_WIDTH-1:0] cnt_d;

    // The count saturates at the threshold; the armed flag makes the press one-shot.
    assign press_o = armed_q && (cnt_q == c_deb_cycles);

    always_comb begin
        cnt_d   = cnt_q;
        armed_d = armed_q;
        if (sync2_q) begin
            cnt_d   = '0;
            armed_d = 1'b1;
        end else begin
            if (cnt_q < c_deb_cycles) begin
                cnt_d = cnt_q + CTR_WIDTH'(1);
            end
            if (press_o) begin
                armed_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            cnt_q   <= '0;
            armed_q <= 1'b1;
        end else begin
            sync1_q <= btn_n_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/reset_seq.sv
// ============================================================================
// Module      : reset_seq
// Description : Staggered multi-domain reset sequencer with software, button
//               and optional watchdog (RESET_SEQ_WDT_EN) re-trigger sources.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reset_seq
    import reset_seq_pkg::*;
#(
    parameter int NUM_RST         = 4,
    parameter int RST_CYCLES      = 100,
    parameter int STAGGER_CYCLES  = 16,
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int WDT_CYCLES      = 1000000,
    parameter int CTR_WIDTH       = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sw_rst_req,
    input  logic               ext_rst_btn_n,
    input  logic               wdt_kick,
    output logic [NUM_RST-1:0] rst_n_out,
    output logic               busy,
    output logic [1:0]         rst_cause
);

    localparam int IDX_W = $clog2(NUM_RST + 1);

    localparam logic [CTR_WIDTH-1:0] c_rst_cycles = CTR_WIDTH'(RST_CYCLES);
    localparam logic [CTR_WIDTH-1:0] c_stagger    = CTR_WIDTH'(STAGGER_CYCLES);
    localparam logic [IDX_W-1:0]     c_last_idx   = IDX_W'(NUM_RST - 1);
    localparam logic [NUM_RST-1:0]   c_one        = NUM_RST'(1);

    generate
        if (!cycles_fit(CTR_WIDTH, RST_CYCLES) || !cycles_fit(CTR_WIDTH, STAGGER_CYCLES) ||
            !cycles_fit(CTR_WIDTH, DEBOUNCE_CYCLES) || !cycles_fit(CTR_WIDTH, WDT_CYCLES) ||
            NUM_RST < 1 || NUM_RST > 16 || DEBOUNCE_CYCLES < 1) begin : g_param_error
            $error("reset_seq: parameter out of range for CTR_WIDTH/NUM_RST");
        end
    endgenerate

    logic [1:0]           state_q;
    logic [1:0]           state_d;
    logic [CTR_WIDTH-1:0] ctr_q;
    logic [CTR_WIDTH-1:0] ctr_d;
    logic [IDX_W-1:0]     idx_q;
    logic [IDX_W-1:0]     idx_d;
    logic [NUM_RST-1:0]   out_q;
    logic [NUM_RST-1:0]   out_d;
    logic [1:0]           cause_q;
    logic [1:0]           cause_d;

    logic                 w_ext_press;
    logic                 w_wdt_expire;
    logic                 w_trigger;

    rst_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CTR_WIDTH       (CTR_WIDTH)
    ) u_debounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_n_i (ext_rst_btn_n),
        .press_o (w_ext_press)
    );

    assign w_trigger = sw_rst_req || w_ext_press || w_wdt_expire;

`ifdef RESET_SEQ_WDT_EN
    localparam logic [CTR_WIDTH-1:0] c_wdt_cycles = CTR_WIDTH'(WDT_CYCLES);

    logic [CTR_WIDTH-1:0] wdt_q;
    logic [CTR_WIDTH-1:0] wdt_d;

    assign w_wdt_expire = (state_q == ST_RUN) && (wdt_q >= c_wdt_cycles);

    always_comb begin
        wdt_d = '0;
        if ((state_q == ST_RUN) && !wdt_kick && !w_trigger) begin
            wdt_d = (wdt_q == '1) ? wdt_q : wdt_q + CTR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wdt_q <= '0;
        end else begin
            wdt_q <= wdt_d;
        end
    end
`else
    logic w_unused_wdt_kick;

    assign w_unused_wdt_kick = wdt_kick;
    assign w_wdt_expire      = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        idx_d   = idx_q;
        out_d   = out_q;
        cause_d = cause_q;
        if (w_trigger) begin
            // The trigger edge is edge 0 of the new hold, so the count starts at 1,
            // matching the count after the first edge out of rst_n.
            state_d = ST_ASSERT;
            ctr_d   = CTR_WIDTH'(1);
            idx_d   = '0;
            out_d   = '0;
            if (w_wdt_expire) begin
                cause_d = CAUSE_WDT;
            end else if (w_ext_press) begin
                cause_d = CAUSE_EXT;
            end else begin
                cause_d = CAUSE_SW;
            end
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    out_d = '0;
                    if (ctr_q >= c_rst_cycles) begin
                        out_d   = c_one;
                        idx_d   = IDX_W'(1);
                        ctr_d   = CTR_WIDTH'(1);
                        state_d = (NUM_RST == 1) ? ST_RUN : ST_RELEASE;
                    end else begin
                        ctr_d = (ctr_q == '1) ? ctr_q : ctr_q + CTR_WIDTH'(1);
                    end
                end
                ST_RELEASE: begin
                    if (ctr_q >= c_stagger) begin
                        out_d = out_q | (c_one << idx_q);
                        idx_d = idx_q + IDX_W'(1);
                        ctr_d = CTR_WIDTH'(1);
                        if (idx_q == c_last_idx) begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        ctr_d = (ctr_q == '1) ? ctr_q : ctr_q + CTR_WIDTH'(1);
                    end
                end
                ST_RUN: begin
                    out_d = '1;
                end
                default: begin
                    state_d = ST_ASSERT;
                    ctr_d   = '0;
                    out_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_ASSERT;
            ctr_q   <= '0;
            idx_q   <= '0;
            out_q   <= '0;
            cause_q <= CAUSE_POR;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
            cause_q <= cause_d;
        end
    end

    assign rst_n_out = out_q;
    assign busy      = ~(&out_q);
    assign rst_cause = cause_q;

endmodule

`default_nettype wire
